activation_control: RTL and testbench



---
 rtl/activation_control_pkg.sv | 51 +++++
 rtl/activation_control_delay_line.sv | 41 ++++
 rtl/activation_control.sv | 210 +++++++++++++++++++++
 tb/tb_activation_control.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/activation_control_pkg.sv
// -----------------------------------------------------------------------------
// activation_control_pkg
// Shared types for the activation sequencer: activation function encoding,
// controller state encoding, the decoded instruction record and a helper
// that derives the accumulator-to-writeback pipeline depth.
// -----------------------------------------------------------------------------
package activation_control_pkg;

    // Activation function selector shared with the activation unit.
    typedef enum logic [3:0] {
        NO_ACTIVATION = 4'd0,
        RELU          = 4'd1,
        RELU6         = 4'd2,
        CRELU         = 4'd3,
        ELU           = 4'd4,
        SELU          = 4'd5,
        SOFTPLUS      = 4'd6,
        SOFTSIGN      = 4'd7,
        DROPOUT       = 4'd8,
        SIGMOID       = 4'd9,
        TANH          = 4'd10
    } ACTIVATION_BIT_TYPE;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } ACT_CTRL_STATE_TYPE;

    // Field widths of the decoded instruction record as produced by the decoder.
    localparam int ACT_INSTR_ACC_ADDR_WIDTH = 16;
    localparam int ACT_INSTR_BUF_ADDR_WIDTH = 24;
    localparam int ACT_INSTR_LEN_WIDTH      = 32;

    // One activation instruction as handed over by the instruction decoder.
    typedef struct packed {
        logic [ACT_INSTR_ACC_ADDR_WIDTH-1:0] acc_addr;
        logic [ACT_INSTR_BUF_ADDR_WIDTH-1:0] buf_addr;
        logic [ACT_INSTR_LEN_WIDTH-1:0]      length;
        ACTIVATION_BIT_TYPE                  act_func;
        logic                                signed_not_unsigned;
    } ACT_INSTR_TYPE;

    // Rows spend the accumulator read latency plus the activation latency in flight.
    function automatic int act_ctrl_pipe_depth(input int acc_read_latency, input int act_latency);
        return acc_read_latency + act_latency;
    endfunction

endpackage

// File: rtl/activation_control_delay_line.sv
// -----------------------------------------------------------------------------
// act_ctrl_delay_line
// Fixed-depth shift register carrying a valid bit and a payload per stage.
// Reset clears every stage so no stale valid can escape after reset.
// -----------------------------------------------------------------------------
module act_ctrl_delay_line #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_payload,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_payload
);

    logic [DEPTH-1:0] r_valid;
    logic [WIDTH-1:0] r_payload [DEPTH];

    // Shift valid and payload one stage per cycle; stage 0 loads the inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i]   <= 1'b0;
                r_payload[i] <= '0;
            end
        end else begin
            r_valid[0]   <= i_valid;
            r_payload[0] <= i_payload;
            for (int i = 1; i < DEPTH; i++) begin
                r_valid[i]   <= r_valid[i-1];
                r_payload[i] <= r_payload[i-1];
            end
        end
    end

    assign o_valid   = r_valid[DEPTH-1];
    assign o_payload = r_payload[DEPTH-1];

endmodule

// File: rtl/activation_control.sv
// -----------------------------------------------------------------------------
// activation_control
// Sequencer for the activation datapath. Accepts one instruction at a time,
// issues one accumulator read per row, carries each row's unified-buffer
// address through a delay line matching the read + activation latency and
// raises the matching buffer write when the row leaves the pipeline.
//
// Optional build macro: ACTIVATION_CONTROL_PERF_EN adds perf_clear/perf_rows,
// a saturating count of unified-buffer write cycles.
// -----------------------------------------------------------------------------
module activation_control
    import activation_control_pkg::*;
#(
    parameter int ACC_ADDR_WIDTH   = 16,
    parameter int BUF_ADDR_WIDTH   = 24,
    parameter int LEN_WIDTH        = 32,
    parameter int ACC_READ_LATENCY = 1,
    parameter int ACT_LATENCY      = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      instr_valid,
    output logic                      instr_ready,
    input  logic [ACC_ADDR_WIDTH-1:0] instr_acc_addr,
    input  logic [BUF_ADDR_WIDTH-1:0] instr_buf_addr,
    input  logic [LEN_WIDTH-1:0]      instr_length,
    input  ACTIVATION_BIT_TYPE        instr_act_func,
    input  logic                      instr_signed,
    output logic                      acc_rd_en,
    output logic [ACC_ADDR_WIDTH-1:0] acc_rd_addr,
    output ACTIVATION_BIT_TYPE        act_function,
    output logic                      act_signed,
    output logic                      buf_wr_en,
    output logic [BUF_ADDR_WIDTH-1:0] buf_wr_addr,
    output logic                      busy,
    output logic                      done
`ifdef ACTIVATION_CONTROL_PERF_EN
    ,
    input  logic                      perf_clear,
    output logic [31:0]               perf_rows
`endif
);

    localparam int PIPE_DEPTH      = act_ctrl_pipe_depth(ACC_READ_LATENCY, ACT_LATENCY);
    localparam int DRAIN_CNT_WIDTH = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
    localparam logic [DRAIN_CNT_WIDTH-1:0] DRAIN_LAST = DRAIN_CNT_WIDTH'(PIPE_DEPTH - 1);

    // Registered state and outputs.
    ACT_CTRL_STATE_TYPE          r_state;
    logic [LEN_WIDTH-1:0]        r_remaining;
    logic [DRAIN_CNT_WIDTH-1:0]  r_drain_cnt;
    logic                        r_acc_rd_en;
    logic [ACC_ADDR_WIDTH-1:0]   r_acc_rd_addr;
    logic [BUF_ADDR_WIDTH-1:0]   r_buf_addr;
    ACTIVATION_BIT_TYPE          r_act_function;
    logic                        r_act_signed;
    logic                        r_done;
    logic                        r_busy;
    logic                        r_instr_ready;

    // Next-state values.
    ACT_CTRL_STATE_TYPE          w_state_nxt;
    logic [LEN_WIDTH-1:0]        w_remaining_nxt;
    logic [DRAIN_CNT_WIDTH-1:0]  w_drain_cnt_nxt;
    logic                        w_acc_rd_en_nxt;
    logic [ACC_ADDR_WIDTH-1:0]   w_acc_rd_addr_nxt;
    logic [BUF_ADDR_WIDTH-1:0]   w_buf_addr_nxt;
    ACTIVATION_BIT_TYPE          w_act_function_nxt;
    logic                        w_act_signed_nxt;
    logic                        w_done_nxt;
    logic                        w_accept;

    // Delay-line output.
    logic                        w_wr_valid;
    logic [BUF_ADDR_WIDTH-1:0]   w_wr_addr;

    assign w_accept = instr_valid && r_instr_ready;

    // Next-state and next-output decode for the sequencer.
    always_comb begin
        w_state_nxt        = r_state;
        w_remaining_nxt    = r_remaining;
        w_drain_cnt_nxt    = r_drain_cnt;
        w_acc_rd_en_nxt    = 1'b0;
        w_acc_rd_addr_nxt  = r_acc_rd_addr;
        w_buf_addr_nxt     = r_buf_addr;
        w_act_function_nxt = r_act_function;
        w_act_signed_nxt   = r_act_signed;
        w_done_nxt         = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_act_function_nxt = instr_act_func;
                    w_act_signed_nxt   = instr_signed;
                    w_remaining_nxt    = instr_length;
                    w_acc_rd_addr_nxt  = instr_acc_addr;
                    w_buf_addr_nxt     = instr_buf_addr;
                    if (instr_length == '0) begin
                        // Zero-length instruction completes without touching the datapath.
                        w_state_nxt = DONE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt     = ISSUE;
                        w_acc_rd_en_nxt = 1'b1;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            ISSUE: begin
                if (r_remaining == LEN_WIDTH'(1)) begin
                    w_state_nxt     = DRAIN;
                    w_drain_cnt_nxt = '0;
                end else begin
                    w_acc_rd_en_nxt   = 1'b1;
                    w_remaining_nxt   = r_remaining - LEN_WIDTH'(1);
                    w_acc_rd_addr_nxt = r_acc_rd_addr + ACC_ADDR_WIDTH'(1);
                    w_buf_addr_nxt    = r_buf_addr + BUF_ADDR_WIDTH'(1);
                end
            end
            DRAIN: begin
                // Wait until the last issued row has left the pipeline.
                if (r_drain_cnt == DRAIN_LAST) begin
                    w_state_nxt = DONE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_drain_cnt_nxt = r_drain_cnt + DRAIN_CNT_WIDTH'(1);
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Sequencer state register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_remaining    <= '0;
            r_drain_cnt    <= '0;
            r_acc_rd_en    <= 1'b0;
            r_acc_rd_addr  <= '0;
            r_buf_addr     <= '0;
            r_act_function <= NO_ACTIVATION;
            r_act_signed   <= 1'b0;
            r_done         <= 1'b0;
            r_busy         <= 1'b0;
            r_instr_ready  <= 1'b1;
        end else begin
            r_state        <= w_state_nxt;
            r_remaining    <= w_remaining_nxt;
            r_drain_cnt    <= w_drain_cnt_nxt;
            r_acc_rd_en    <= w_acc_rd_en_nxt;
            r_acc_rd_addr  <= w_acc_rd_addr_nxt;
            r_buf_addr     <= w_buf_addr_nxt;
            r_act_function <= w_act_function_nxt;
            r_act_signed   <= w_act_signed_nxt;
            r_done         <= w_done_nxt;
            r_busy         <= (w_state_nxt != IDLE);
            r_instr_ready  <= (w_state_nxt == IDLE);
        end
    end

    // Each read carries its destination row through the fixed pipeline latency.
    act_ctrl_delay_line #(
        .DEPTH (PIPE_DEPTH),
        .WIDTH (BUF_ADDR_WIDTH)
    ) u_delay_line (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (r_acc_rd_en),
        .i_payload (r_buf_addr),
        .o_valid   (w_wr_valid),
        .o_payload (w_wr_addr)
    );

    assign instr_ready  = r_instr_ready;
    assign busy         = r_busy;
    assign done         = r_done;
    assign acc_rd_en    = r_acc_rd_en;
    assign acc_rd_addr  = r_acc_rd_addr;
    assign act_function = r_act_function;
    assign act_signed   = r_act_signed;
    assign buf_wr_en    = w_wr_valid;
    assign buf_wr_addr  = w_wr_addr;

`ifdef ACTIVATION_CONTROL_PERF_EN
    logic [31:0] r_perf_rows;

    // Saturating written-row counter; a clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_rows <= 32'd0;
        end else if (perf_clear) begin
            r_perf_rows <= 32'd0;
        end else if (w_wr_valid && (r_perf_rows != 32'hFFFF_FFFF)) begin
            r_perf_rows <= r_perf_rows + 32'd1;
        end else begin
            r_perf_rows <= r_perf_rows;
        end
    end

    assign perf_rows = r_perf_rows;
`endif

endmodule

// File: tb/tb_activation_control.sv
// -----------------------------------------------------------------------------
// tb_activation_control
// Directed self-checking bench for activation_control with default parameters
// (pipeline depth 4). Inputs change and outputs are sampled 1 time unit after
// the rising edge; "cycle n" is the interval after accept edge + n edges.
// -----------------------------------------------------------------------------
module tb_activation_control;
    import activation_control_pkg::*;

    localparam int PIPE = 4;

    logic               clk;
    logic               rst;
    logic               instr_valid;
    logic               instr_ready;
    logic [15:0]        instr_acc_addr;
    logic [23:0]        instr_buf_addr;
    logic [31:0]        instr_length;
    ACTIVATION_BIT_TYPE instr_act_func;
    logic               instr_signed;
    logic               acc_rd_en;
    logic [15:0]        acc_rd_addr;
    ACTIVATION_BIT_TYPE act_function;
    logic               act_signed;
    logic               buf_wr_en;
    logic [23:0]        buf_wr_addr;
    logic               busy;
    logic               done;
`ifdef ACTIVATION_CONTROL_PERF_EN
    logic               perf_clear;
    logic [31:0]        perf_rows;
`endif

    int checks;
    int failures;

    activation_control #(
        .ACC_ADDR_WIDTH   (16),
        .BUF_ADDR_WIDTH   (24),
        .LEN_WIDTH        (32),
        .ACC_READ_LATENCY (1),
        .ACT_LATENCY      (3)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_acc_addr (instr_acc_addr),
        .instr_buf_addr (instr_buf_addr),
        .instr_length   (instr_length),
        .instr_act_func (instr_act_func),
        .instr_signed   (instr_signed),
        .acc_rd_en      (acc_rd_en),
        .acc_rd_addr    (acc_rd_addr),
        .act_function   (act_function),
        .act_signed     (act_signed),
        .buf_wr_en      (buf_wr_en),
        .buf_wr_addr    (buf_wr_addr),
        .busy           (busy),
        .done           (done)
`ifdef ACTIVATION_CONTROL_PERF_EN
        ,
        .perf_clear     (perf_clear),
        .perf_rows      (perf_rows)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one instruction at the current cycle; returns one step after the accept edge.
    task automatic accept_instr(input logic [15:0] a, input logic [23:0] b, input logic [31:0] l,
                                input ACTIVATION_BIT_TYPE f, input logic s);
        checks++;
        if (instr_ready !== 1'b1) begin
            failures++;
            $display("FAIL accept_ready: instr_ready=%b required 1", instr_ready);
        end
        instr_valid    = 1'b1;
        instr_acc_addr = a;
        instr_buf_addr = b;
        instr_length   = l;
        instr_act_func = f;
        instr_signed   = s;
        step();
        instr_valid    = 1'b0;
        instr_acc_addr = 16'h5A5A;
        instr_buf_addr = 24'hA5A5A5;
        instr_length   = 32'd7;
        instr_act_func = SELU;
        instr_signed   = ~s;
    endtask

    // Follow an accepted instruction cycle by cycle from cycle 1 until back in idle.
    task automatic track_instr(input string nm, input logic [15:0] a, input logic [23:0] b,
                               input int l, input ACTIVATION_BIT_TYPE f, input logic s);
        int          last_busy;
        logic        e_rd_en, e_wr_en, e_done, e_busy;
        logic [15:0] e_rd_addr;
        logic [23:0] e_wr_addr;
        last_busy = (l == 0) ? 1 : l + PIPE + 1;
        for (int cyc = 1; cyc <= last_busy + 2; cyc++) begin
            e_rd_en   = (cyc <= l);
            e_rd_addr = a + 16'(cyc - 1);
            e_wr_en   = (cyc >= 1 + PIPE) && (cyc <= l + PIPE);
            e_wr_addr = b + 24'(cyc - 1 - PIPE);
            e_done    = (cyc == last_busy);
            e_busy    = (cyc <= last_busy);
            checks += 6;
            if (acc_rd_en !== e_rd_en) begin
                failures++;
                $display("FAIL %s rd_en cyc%0d: got %b required %b", nm, cyc, acc_rd_en, e_rd_en);
            end
            if (buf_wr_en !== e_wr_en) begin
                failures++;
                $display("FAIL %s wr_en cyc%0d: got %b required %b", nm, cyc, buf_wr_en, e_wr_en);
            end
            if (done !== e_done) begin
                failures++;
                $display("FAIL %s done cyc%0d: got %b required %b", nm, cyc, done, e_done);
            end
            if (busy !== e_busy || instr_ready !== ~e_busy) begin
                failures++;
                $display("FAIL %s busy/ready cyc%0d: got %b/%b required %b/%b", nm, cyc, busy, instr_ready, e_busy, ~e_busy);
            end
            if (act_function !== f) begin
                failures++;
                $display("FAIL %s act_function cyc%0d: got %0d required %0d", nm, cyc, act_function, f);
            end
            if (act_signed !== s) begin
                failures++;
                $display("FAIL %s act_signed cyc%0d: got %b required %b", nm, cyc, act_signed, s);
            end
            if (e_rd_en) begin
                checks++;
                if (acc_rd_addr !== e_rd_addr) begin
                    failures++;
                    $display("FAIL %s rd_addr cyc%0d: got %h required %h", nm, cyc, acc_rd_addr, e_rd_addr);
                end
            end
            if (e_wr_en) begin
                checks++;
                if (buf_wr_addr !== e_wr_addr) begin
                    failures++;
                    $display("FAIL %s wr_addr cyc%0d: got %h required %h", nm, cyc, buf_wr_addr, e_wr_addr);
                end
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        instr_valid    = 1'b0;
        instr_acc_addr = 16'd0;
        instr_buf_addr = 24'd0;
        instr_length   = 32'd0;
        instr_act_func = NO_ACTIVATION;
        instr_signed   = 1'b0;
`ifdef ACTIVATION_CONTROL_PERF_EN
        perf_clear     = 1'b0;
`endif
        step();
        step();
        checks++;
        if ({instr_ready, busy, done, acc_rd_en, buf_wr_en, act_signed} !== 6'b100000) begin
            failures++;
            $display("FAIL reset_flags: ready,busy,done,rd,wr,sgn=%b required 100000",
                     {instr_ready, busy, done, acc_rd_en, buf_wr_en, act_signed});
        end
        checks++;
        if (acc_rd_addr !== 16'd0 || buf_wr_addr !== 24'd0) begin
            failures++;
            $display("FAIL reset_addr: rd=%h wr=%h required 0/0", acc_rd_addr, buf_wr_addr);
        end
        checks++;
        if (act_function !== NO_ACTIVATION) begin
            failures++;
            $display("FAIL reset_func: got %0d required 0", act_function);
        end
        rst = 1'b0;
        step();
        checks++;
        if (instr_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: ready=%b busy=%b required 1/0", instr_ready, busy);
        end
    endtask

    task automatic test_basic();
        accept_instr(16'd10, 24'd100, 32'd4, RELU, 1'b0);
        track_instr("basic_l4", 16'd10, 24'd100, 4, RELU, 1'b0);
        accept_instr(16'h1234, 24'hABCDEF, 32'd1, ELU, 1'b1);
        track_instr("single_row", 16'h1234, 24'hABCDEF, 1, ELU, 1'b1);
    endtask

    task automatic test_zero_len();
        accept_instr(16'd33, 24'd44, 32'd0, SIGMOID, 1'b1);
        track_instr("zero_len", 16'd33, 24'd44, 0, SIGMOID, 1'b1);
    endtask

    task automatic test_wrap();
        accept_instr(16'hFFFE, 24'h000200, 32'd4, RELU6, 1'b0);
        track_instr("acc_wrap", 16'hFFFE, 24'h000200, 4, RELU6, 1'b0);
        accept_instr(16'h0100, 24'hFFFFFF, 32'd3, SOFTSIGN, 1'b1);
        track_instr("buf_wrap", 16'h0100, 24'hFFFFFF, 3, SOFTSIGN, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic e_rd_en, e_wr_en;
        instr_valid    = 1'b1;
        instr_acc_addr = 16'd20;
        instr_buf_addr = 24'd300;
        instr_length   = 32'd3;
        instr_act_func = CRELU;
        instr_signed   = 1'b1;
        step();
        for (int cyc = 1; cyc <= 9; cyc++) begin
            e_rd_en = (cyc <= 3);
            e_wr_en = (cyc >= 5) && (cyc <= 7);
            checks += 5;
            if (acc_rd_en !== e_rd_en || (e_rd_en && acc_rd_addr !== 16'(20 + cyc - 1))) begin
                failures++;
                $display("FAIL b2b_read cyc%0d: en=%b addr=%0d required en=%b addr=%0d", cyc, acc_rd_en, acc_rd_addr, e_rd_en, 20 + cyc - 1);
            end
            if (buf_wr_en !== e_wr_en || (e_wr_en && buf_wr_addr !== 24'(300 + cyc - 5))) begin
                failures++;
                $display("FAIL b2b_write cyc%0d: en=%b addr=%0d required en=%b addr=%0d", cyc, buf_wr_en, buf_wr_addr, e_wr_en, 300 + cyc - 5);
            end
            if (done !== (cyc == 8)) begin
                failures++;
                $display("FAIL b2b_done cyc%0d: got %b required %b", cyc, done, (cyc == 8));
            end
            if (instr_ready !== (cyc == 9)) begin
                failures++;
                $display("FAIL b2b_ready cyc%0d: got %b required %b", cyc, instr_ready, (cyc == 9));
            end
            if (act_function !== CRELU || act_signed !== 1'b1) begin
                failures++;
                $display("FAIL b2b_func cyc%0d: got %0d/%b required %0d/1", cyc, act_function, act_signed, CRELU);
            end
            if (cyc == 1) begin
                instr_acc_addr = 16'd777;
                instr_buf_addr = 24'd888;
                instr_length   = 32'd6;
                instr_act_func = SOFTPLUS;
                instr_signed   = 1'b0;
            end
            if (cyc == 6) begin
                instr_acc_addr = 16'd40;
                instr_buf_addr = 24'd500;
                instr_length   = 32'd2;
                instr_act_func = TANH;
                instr_signed   = 1'b0;
            end
            step();
        end
        instr_valid = 1'b0;
        track_instr("b2b_second", 16'd40, 24'd500, 2, TANH, 1'b0);
    endtask

    task automatic test_reset_mid();
        accept_instr(16'd0, 24'd0, 32'd8, RELU, 1'b1);
        checks++;
        if (acc_rd_en !== 1'b1 || acc_rd_addr !== 16'd0) begin
            failures++;
            $display("FAIL mid_read0: en=%b addr=%0d required 1/0", acc_rd_en, acc_rd_addr);
        end
        step();
        checks++;
        if (acc_rd_en !== 1'b1 || acc_rd_addr !== 16'd1) begin
            failures++;
            $display("FAIL mid_read1: en=%b addr=%0d required 1/1", acc_rd_en, acc_rd_addr);
        end
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks += 3;
        if ({instr_ready, busy, done, acc_rd_en, buf_wr_en, act_signed} !== 6'b100000) begin
            failures++;
            $display("FAIL mid_reset_flags: ready,busy,done,rd,wr,sgn=%b required 100000",
                     {instr_ready, busy, done, acc_rd_en, buf_wr_en, act_signed});
        end
        if (acc_rd_addr !== 16'd0 || buf_wr_addr !== 24'd0) begin
            failures++;
            $display("FAIL mid_reset_addr: rd=%h wr=%h required 0/0", acc_rd_addr, buf_wr_addr);
        end
        if (act_function !== NO_ACTIVATION) begin
            failures++;
            $display("FAIL mid_reset_func: got %0d required 0", act_function);
        end
        for (int cyc = 0; cyc < 12; cyc++) begin
            checks++;
            if (buf_wr_en !== 1'b0 || acc_rd_en !== 1'b0 || instr_ready !== 1'b1) begin
                failures++;
                $display("FAIL mid_after_reset cyc%0d: wr=%b rd=%b ready=%b required 0/0/1", cyc, buf_wr_en, acc_rd_en, instr_ready);
            end
            step();
        end
    endtask

`ifdef ACTIVATION_CONTROL_PERF_EN
    task automatic test_perf();
        perf_clear = 1'b1;
        step();
        perf_clear = 1'b0;
        checks++;
        if (perf_rows !== 32'd0) begin
            failures++;
            $display("FAIL perf_initial_clear: got %0d required 0", perf_rows);
        end
        accept_instr(16'd1, 24'd1, 32'd5, RELU, 1'b0);
        track_instr("perf_l5", 16'd1, 24'd1, 5, RELU, 1'b0);
        accept_instr(16'd9, 24'd9, 32'd3, RELU, 1'b0);
        track_instr("perf_l3", 16'd9, 24'd9, 3, RELU, 1'b0);
        checks++;
        if (perf_rows !== 32'd8) begin
            failures++;
            $display("FAIL perf_count: got %0d required 8", perf_rows);
        end
        perf_clear = 1'b1;
        step();
        perf_clear = 1'b0;
        checks++;
        if (perf_rows !== 32'd0) begin
            failures++;
            $display("FAIL perf_clear: got %0d required 0", perf_rows);
        end
        accept_instr(16'd3, 24'd3, 32'd2, RELU, 1'b0);
        for (int cyc = 1; cyc <= 8; cyc++) begin
            if (cyc == 6) begin
                checks++;
                if (buf_wr_en !== 1'b1 || perf_rows !== 32'd1) begin
                    failures++;
                    $display("FAIL perf_pre_clash: wr=%b rows=%0d required 1/1", buf_wr_en, perf_rows);
                end
                perf_clear = 1'b1;
            end else begin
                perf_clear = 1'b0;
            end
            step();
        end
        perf_clear = 1'b0;
        checks++;
        if (perf_rows !== 32'd0) begin
            failures++;
            $display("FAIL perf_clear_vs_write: got %0d required 0", perf_rows);
        end
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_zero_len();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
`ifdef ACTIVATION_CONTROL_PERF_EN
        test_perf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
